multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter WAIT_MAX, default 15, is the memory wait-cycle limit before a bus error is declared (legal 1..255).
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 opcode  input  6  instruction[31:26] from the instruction register.
REQ-005 alu_zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completes the current read/write this cycle.
REQ-007 ir_write  output  1  load instruction register.
REQ-008 pc_write  output  1  unconditional PC load.
REQ-009 pc_write_cond  output  1  PC load qualified by alu_zero (beq).
REQ-010 pc_src  output  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-011 ext_sel  output  1  0 sign-extend, 1 zero-extend; selects the immediate extender output.
REQ-012 alu_src_a  output  1  0 PC, 1 register A.
REQ-013 alu_src_b  output  2  00 reg B, 01 const 4, 10 extended imm, 11 sign-ext imm<<2.
REQ-014 alu_op  output  3  000 add, 001 sub, 010 R-type funct, 011 and, 100 or, 101 slt.
REQ-015 mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg  output  1 each  standard multicycle datapath controls (iord 1 = data address).
REQ-016 illegal_op  output  1  one-cycle pulse on unsupported opcode.
REQ-017 bus_err  output  1  one-cycle pulse on memory timeout.
REQ-018 state  output  4  current state encoding, for debug.

Function
REQ-019 States (encoding): FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, REXEC 6, RWB 7, BRANCH 8, JUMP 9, IEXEC 10, IWB 11; others unreachable and SHALL return to FETCH.
REQ-020 Outputs SHALL be Moore, decoded from state plus opcode (IEXEC/IWB only); undriven controls are 0.
REQ-021 FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000; ir_write=pc_write=mem_ready; stay while mem_ready=0, else -> DECODE.
REQ-022 DECODE: alu_src_a=0, alu_src_b=11, ext_sel=0, alu_op=000; next by opcode: 000000 REXEC; 100011/101011 MEMADR; 000100 BRANCH; 000010 JUMP; 001000/001010/001100/001101 IEXEC; any other -> FETCH with illegal_op=1.
REQ-023 MEMADR: alu_src_a=1, alu_src_b=10, ext_sel=0, alu_op=000; lw -> MEMRD, sw -> MEMWR.
REQ-024 MEMRD: mem_read=1, iord=1; hold until mem_ready, then MEMWB. MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0; -> FETCH.
REQ-025 MEMWR: mem_write=1, iord=1; hold until mem_ready, then FETCH.
REQ-026 REXEC: alu_src_a=1, alu_src_b=00, alu_op=010; -> RWB. RWB: reg_write=1, reg_dst=1; -> FETCH.
REQ-027 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=001, pc_write_cond=1, pc_src=01; -> FETCH.
REQ-028 JUMP: pc_write=1, pc_src=10; -> FETCH.
REQ-029 IEXEC: alu_src_a=1, alu_src_b=10; addi ext_sel=0 op 000; slti ext_sel=0 op 101; andi ext_sel=1 op 011; ori ext_sel=1 op 100; -> IWB. IWB: reg_write=1, reg_dst=0, mem_to_reg=0, ext_sel held as in IEXEC; -> FETCH.
REQ-030 An 8-bit wait counter SHALL increment each cycle in FETCH/MEMRD/MEMWR with mem_ready=0, clear on any state change or mem_ready=1.
REQ-031 When the counter equals WAIT_MAX with mem_ready still 0: bus_err=1 that cycle, mem_read/mem_write deasserted next cycle, next state FETCH, counter cleared; ir_write/pc_write/reg_write not asserted.
REQ-032 mem_ready=1 in the same cycle the counter reaches WAIT_MAX SHALL complete normally, no bus_err.
REQ-033 Instruction latency: R/I-type 4 cycles, lw 5, sw 4, beq 3, j 3, each with zero wait states.

Reset
REQ-034 rst_n low SHALL immediately force state=FETCH, counter=0, and all outputs 0 (including mem_read) until rst_n rises.
REQ-035 Reset mid-instruction SHALL abandon it with no register or memory write; first post-reset cycle behaves as FETCH.

Structure
REQ-036 State encodings, opcode constants and alu_op codes SHALL live in the shared package mcpu_pkg.
REQ-037 The wait counter/timeout SHALL be a sub-module mem_wait_timer.

Verification
REQ-038 addi (opcode 001000), mem_ready=1 always -> states 0,1,10,11,0; ext_sel=0, reg_write=1 in cycle 4.
REQ-039 ori (001101) -> ext_sel=1 in IEXEC and IWB, alu_op=100.
REQ-040 lw, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, then MEMWB with mem_to_reg=1; no bus_err.
REQ-041 WAIT_MAX=4, mem_ready stuck 0 in FETCH -> bus_err pulse on 5th FETCH cycle, ir_write never 1, returns to FETCH.
REQ-042 opcode 111111 -> illegal_op pulse in DECODE, next state FETCH, no writes.
REQ-043 rst_n low during MEMWR -> mem_write=0 immediately; after release state=0.

Source files
------------

// File: rtl/mcpu_pkg.sv
// rtl/mcpu_pkg.sv - shared encodings and decode helpers for the multicycle controller
package mcpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_IEXEC  = 4'd10,
    S_IWB    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BRANCH = 2'b11;

  typedef struct packed {
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       ext_sel;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       mem_read;
    logic       mem_write;
    logic       iord;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic       bus_err;
  } ctrl_t;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J,
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: is_legal = 1'b1;
      default:                          is_legal = 1'b0;
    endcase
  endfunction

  // Returns {ext_sel, alu_op} for the immediate-ALU group; unknown codes act as addi.
  function automatic logic [3:0] imm_decode(input logic [5:0] op);
    case (op)
      OP_SLTI: imm_decode = {1'b0, ALU_SLT};
      OP_ANDI: imm_decode = {1'b1, ALU_AND};
      OP_ORI:  imm_decode = {1'b1, ALU_OR};
      default: imm_decode = {1'b0, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - memory wait-state counter with timeout detection
module mem_wait_timer
  import mcpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam logic [7:0] LIMIT = 8'(WAIT_MAX);

  logic [7:0] count_q;

  // Leaving a wait state only happens on mem_ready or timeout, so both clear the count.
  assign timeout = waiting && !mem_ready && (count_q == LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else if (!waiting || mem_ready || timeout) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_q + 8'd1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle CPU control FSM with memory timeout handling
module multicycle_control
  import mcpu_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       ext_sel,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state
);

  state_t     state_q;
  state_t     state_d;
  logic       abort_q;
  logic       waiting;
  logic       timeout;
  logic       unused_zero;
  logic [3:0] imm_ctrl;
  ctrl_t      ctrl;

  // alu_zero qualifies pc_write_cond in the datapath, not here.
  assign unused_zero = alu_zero;

  // abort_q marks the recovery cycle after a timeout, where the bus stays idle.
  assign waiting  = !abort_q &&
                    ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR));
  assign imm_ctrl = imm_decode(opcode);

  mem_wait_timer #(
    .WAIT_MAX (WAIT_MAX)
  ) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .waiting   (waiting),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_comb begin
    state_d = state_q;
    if (timeout) begin
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  if (mem_ready && !abort_q) state_d = S_DECODE;
        S_DECODE: begin
          case (opcode)
            OP_RTYPE:                          state_d = S_REXEC;
            OP_LW, OP_SW:                      state_d = S_MEMADR;
            OP_BEQ:                            state_d = S_BRANCH;
            OP_J:                              state_d = S_JUMP;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_IEXEC;
            default:                           state_d = S_FETCH;
          endcase
        end
        S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
        S_MEMWR:  if (mem_ready) state_d = S_FETCH;
        S_REXEC:  state_d = S_RWB;
        S_IEXEC:  state_d = S_IWB;
        S_MEMWB, S_RWB, S_BRANCH, S_JUMP, S_IWB: state_d = S_FETCH;
        default:  state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      abort_q <= timeout;
    end
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = !abort_q;
        ctrl.ir_write  = mem_ready && !abort_q;
        ctrl.pc_write  = mem_ready && !abort_q;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b  = SRCB_BRANCH;
        ctrl.alu_op     = ALU_ADD;
        ctrl.illegal_op = !is_legal(opcode);
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_REXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_src        = PC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write = 1'b1;
        ctrl.pc_src   = PC_JUMP;
      end
      S_IEXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.ext_sel   = imm_ctrl[3];
        ctrl.alu_op    = imm_ctrl[2:0];
      end
      S_IWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.ext_sel   = imm_ctrl[3];
      end
      default: ctrl = '0;
    endcase
    ctrl.bus_err = timeout;
    // Reset silences every control line at once, without waiting for a clock edge.
    if (!rst_n) ctrl = '0;
  end

  assign ir_write      = ctrl.ir_write;
  assign pc_write      = ctrl.pc_write;
  assign pc_write_cond = ctrl.pc_write_cond;
  assign pc_src        = ctrl.pc_src;
  assign ext_sel       = ctrl.ext_sel;
  assign alu_src_a     = ctrl.alu_src_a;
  assign alu_src_b     = ctrl.alu_src_b;
  assign alu_op        = ctrl.alu_op;
  assign mem_read      = ctrl.mem_read;
  assign mem_write     = ctrl.mem_write;
  assign iord          = ctrl.iord;
  assign reg_write     = ctrl.reg_write;
  assign reg_dst       = ctrl.reg_dst;
  assign mem_to_reg    = ctrl.mem_to_reg;
  assign illegal_op    = ctrl.illegal_op;
  assign bus_err       = ctrl.bus_err;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic       irw, pcw, pcc;
    logic [1:0] pcs;
    logic       ext, asa;
    logic [1:0] asb;
    logic [2:0] aop;
    logic       mr, mw, iord, rw, rd, m2r, ill, berr;
  } obs_t;

  localparam logic [5:0] ADDI = 6'b001000, ORI = 6'b001101, ANDI = 6'b001100;
  localparam logic [5:0] RTYP = 6'b000000, LW = 6'b100011, SW = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100, JMP = 6'b000010, BAD = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       ir_write, pc_write, pc_write_cond, ext_sel, alu_src_a;
  logic [1:0] pc_src, alu_src_b;
  logic [2:0] alu_op;
  logic       mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg;
  logic       illegal_op, bus_err;
  logic [3:0] state;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .alu_zero(alu_zero), .mem_ready(mem_ready),
    .ir_write(ir_write), .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src),
    .ext_sel(ext_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .reg_write(reg_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .illegal_op(illegal_op), .bus_err(bus_err),
    .state(state)
  );

  function automatic obs_t z(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    return o;
  endfunction

  function automatic obs_t o_fetch(input logic r, input logic be);
    obs_t o;
    o = z(4'd0); o.irw = r; o.pcw = r; o.asb = 2'b01; o.mr = 1'b1; o.berr = be;
    return o;
  endfunction

  function automatic obs_t o_abort();
    obs_t o;
    o = z(4'd0); o.asb = 2'b01;
    return o;
  endfunction

  function automatic obs_t o_dec(input logic ill);
    obs_t o;
    o = z(4'd1); o.asb = 2'b11; o.ill = ill;
    return o;
  endfunction

  function automatic obs_t o_memadr();
    obs_t o;
    o = z(4'd2); o.asa = 1'b1; o.asb = 2'b10;
    return o;
  endfunction

  function automatic obs_t o_memrd();
    obs_t o;
    o = z(4'd3); o.mr = 1'b1; o.iord = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_memwb();
    obs_t o;
    o = z(4'd4); o.rw = 1'b1; o.m2r = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_memwr(input logic be);
    obs_t o;
    o = z(4'd5); o.mw = 1'b1; o.iord = 1'b1; o.berr = be;
    return o;
  endfunction

  function automatic obs_t o_rexec();
    obs_t o;
    o = z(4'd6); o.asa = 1'b1; o.aop = 3'b010;
    return o;
  endfunction

  function automatic obs_t o_rwb();
    obs_t o;
    o = z(4'd7); o.rw = 1'b1; o.rd = 1'b1;
    return o;
  endfunction

  function automatic obs_t o_branch();
    obs_t o;
    o = z(4'd8); o.asa = 1'b1; o.aop = 3'b001; o.pcc = 1'b1; o.pcs = 2'b01;
    return o;
  endfunction

  function automatic obs_t o_jump();
    obs_t o;
    o = z(4'd9); o.pcw = 1'b1; o.pcs = 2'b10;
    return o;
  endfunction

  function automatic obs_t o_iexec(input logic ext, input logic [2:0] aop);
    obs_t o;
    o = z(4'd10); o.asa = 1'b1; o.asb = 2'b10; o.ext = ext; o.aop = aop;
    return o;
  endfunction

  function automatic obs_t o_iwb(input logic ext);
    obs_t o;
    o = z(4'd11); o.rw = 1'b1; o.ext = ext;
    return o;
  endfunction

  task automatic step(input logic r, input logic [5:0] op, input logic rdy,
                      input obs_t e, input string tag);
    @(posedge clk);
    #1;
    rst_n = r;
    opcode = op;
    mem_ready = rdy;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t  e;
      obs_t  a;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {state, ir_write, pc_write, pc_write_cond, pc_src, ext_sel, alu_src_a, alu_src_b,
           alu_op, mem_read, mem_write, iord, reg_write, reg_dst, mem_to_reg, illegal_op, bus_err};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s: actual=%h required=%h", t, a, e);
      end
    end
  end

  initial begin
    repeat (3) step(1'b0, ADDI, 1'b1, z(4'd0), "reset");

    step(1'b1, ADDI, 1'b1, o_fetch(1'b1, 1'b0), "addi_fetch");
    step(1'b1, ADDI, 1'b1, o_dec(1'b0), "addi_decode");
    step(1'b1, ADDI, 1'b1, o_iexec(1'b0, 3'b000), "addi_iexec");
    step(1'b1, ADDI, 1'b1, o_iwb(1'b0), "addi_iwb");

    step(1'b1, ORI, 1'b1, o_fetch(1'b1, 1'b0), "ori_fetch");
    step(1'b1, ORI, 1'b1, o_dec(1'b0), "ori_decode");
    step(1'b1, ORI, 1'b1, o_iexec(1'b1, 3'b100), "ori_iexec");
    step(1'b1, ORI, 1'b1, o_iwb(1'b1), "ori_iwb");

    step(1'b1, ANDI, 1'b1, o_fetch(1'b1, 1'b0), "andi_fetch");
    step(1'b1, ANDI, 1'b1, o_dec(1'b0), "andi_decode");
    step(1'b1, ANDI, 1'b1, o_iexec(1'b1, 3'b011), "andi_iexec");
    step(1'b1, ANDI, 1'b1, o_iwb(1'b1), "andi_iwb");

    step(1'b1, RTYP, 1'b1, o_fetch(1'b1, 1'b0), "r_fetch");
    step(1'b1, RTYP, 1'b1, o_dec(1'b0), "r_decode");
    step(1'b1, RTYP, 1'b1, o_rexec(), "r_exec");
    step(1'b1, RTYP, 1'b1, o_rwb(), "r_wb");

    step(1'b1, LW, 1'b1, o_fetch(1'b1, 1'b0), "lw_fetch");
    step(1'b1, LW, 1'b1, o_dec(1'b0), "lw_decode");
    step(1'b1, LW, 1'b1, o_memadr(), "lw_memadr");
    repeat (3) step(1'b1, LW, 1'b0, o_memrd(), "lw_memrd_wait");
    step(1'b1, LW, 1'b1, o_memrd(), "lw_memrd_done");
    step(1'b1, LW, 1'b1, o_memwb(), "lw_memwb");

    step(1'b1, SW, 1'b1, o_fetch(1'b1, 1'b0), "sw_fetch");
    step(1'b1, SW, 1'b1, o_dec(1'b0), "sw_decode");
    step(1'b1, SW, 1'b1, o_memadr(), "sw_memadr");
    step(1'b1, SW, 1'b1, o_memwr(1'b0), "sw_memwr");

    step(1'b1, BEQ, 1'b1, o_fetch(1'b1, 1'b0), "beq_fetch");
    step(1'b1, BEQ, 1'b1, o_dec(1'b0), "beq_decode");
    step(1'b1, BEQ, 1'b1, o_branch(), "beq_branch");

    step(1'b1, JMP, 1'b1, o_fetch(1'b1, 1'b0), "j_fetch");
    step(1'b1, JMP, 1'b1, o_dec(1'b0), "j_decode");
    step(1'b1, JMP, 1'b1, o_jump(), "j_jump");

    step(1'b1, BAD, 1'b1, o_fetch(1'b1, 1'b0), "ill_fetch");
    step(1'b1, BAD, 1'b1, o_dec(1'b1), "ill_decode");
    step(1'b1, JMP, 1'b0, o_fetch(1'b0, 1'b0), "ill_refetch");

    repeat (3) step(1'b1, JMP, 1'b0, o_fetch(1'b0, 1'b0), "fto_wait");
    step(1'b1, JMP, 1'b0, o_fetch(1'b0, 1'b1), "fto_bus_err");
    step(1'b1, JMP, 1'b1, o_abort(), "fto_abort");
    step(1'b1, JMP, 1'b1, o_fetch(1'b1, 1'b0), "fto_refetch");
    step(1'b1, JMP, 1'b1, o_dec(1'b0), "fto_decode");
    step(1'b1, JMP, 1'b1, o_jump(), "fto_jump");

    repeat (4) step(1'b1, JMP, 1'b0, o_fetch(1'b0, 1'b0), "fb_wait");
    step(1'b1, JMP, 1'b1, o_fetch(1'b1, 1'b0), "fb_ready_at_limit");
    step(1'b1, JMP, 1'b1, o_dec(1'b0), "fb_decode");
    step(1'b1, JMP, 1'b1, o_jump(), "fb_jump");

    step(1'b1, SW, 1'b1, o_fetch(1'b1, 1'b0), "swto_fetch");
    step(1'b1, SW, 1'b1, o_dec(1'b0), "swto_decode");
    step(1'b1, SW, 1'b1, o_memadr(), "swto_memadr");
    repeat (4) step(1'b1, SW, 1'b0, o_memwr(1'b0), "swto_wait");
    step(1'b1, SW, 1'b0, o_memwr(1'b1), "swto_bus_err");
    step(1'b1, SW, 1'b1, o_abort(), "swto_abort");

    step(1'b1, SW, 1'b1, o_fetch(1'b1, 1'b0), "rst_fetch");
    step(1'b1, SW, 1'b1, o_dec(1'b0), "rst_decode");
    step(1'b1, SW, 1'b1, o_memadr(), "rst_memadr");
    step(1'b1, SW, 1'b0, o_memwr(1'b0), "rst_memwr");
    step(1'b0, SW, 1'b1, z(4'd0), "rst_during_memwr");
    step(1'b0, SW, 1'b1, z(4'd0), "rst_held");
    step(1'b1, JMP, 1'b1, o_fetch(1'b1, 1'b0), "rst_after_fetch");
    step(1'b1, JMP, 1'b1, o_dec(1'b0), "rst_after_decode");
    step(1'b1, JMP, 1'b1, o_jump(), "rst_after_jump");

    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: actual=%0d pending required=0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
